// File: rtl/vga_sprite_table_engine.sv
// Sprite renderer: loads a RAM-resident X/Y/enable table during vblank, then fetches sprite pixels.
// Optional SPRITE_HFLIP_EN: word 2i+1 bit14 mirrors that sprite horizontally.
module vga_sprite_table_engine #(
    parameter int unsigned NUM_SPRITES   = 4,
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter logic [ADDR_WIDTH-1:0] POS_BASE = 16'h8000,
    parameter logic [ADDR_WIDTH-1:0] SPR_BASE = 16'h0000,
    parameter int unsigned SPR_STRIDE    = 1024,
    parameter int unsigned SPRITE_WIDTH  = 32,
    parameter int unsigned SPRITE_HEIGHT = 32,
    parameter int unsigned SCALE         = 3,
    parameter int unsigned V_ACTIVE      = 480,
    parameter logic [23:0] BG_RGB        = 24'h88CC88
) (
    input  logic                  pix_clk,
    input  logic                  reset,
    input  logic [9:0]            hcount,
    input  logic [9:0]            vcount,
    input  logic                  bright,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [15:0]           ram_q,
    output logic [7:0]            vga_r,
    output logic [7:0]            vga_g,
    output logic [7:0]            vga_b,
    output logic                  bright_out,
    output logic                  load_done,
    output logic                  collision
);

    localparam int unsigned NW = 2 * NUM_SPRITES;
    localparam int unsigned IW = $clog2(NW);
    localparam int unsigned SW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [10:0] SPAN_X = 11'(SPRITE_WIDTH * SCALE);
    localparam logic [10:0] SPAN_Y = 11'(SPRITE_HEIGHT * SCALE);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_COMMIT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            capture, commit, ld_addr_en, vblank_start, fetch_en;
    logic [ADDR_WIDTH-1:0] ld_addr;

    logic [9:0] sh_x_q [NUM_SPRITES];
    logic [9:0] sh_y_q [NUM_SPRITES];
    logic       sh_en_q [NUM_SPRITES];
    logic [9:0] act_x_q [NUM_SPRITES];
    logic [9:0] act_y_q [NUM_SPRITES];
    logic       act_en_q [NUM_SPRITES];
`ifdef SPRITE_HFLIP_EN
    logic       sh_fl_q [NUM_SPRITES];
    logic       act_fl_q [NUM_SPRITES];
`endif

    logic [NUM_SPRITES-1:0] hit;
    logic                   any_hit, multi_hit;
    logic [SW-1:0]          win;
    logic [9:0]             dx, dy, col, row;
    logic [ADDR_WIDTH-1:0]  fetch_addr, ram_addr_q, ram_addr_d;
    logic                   v1_q, v2_q, b1_q, b2_q, bright_out_q, load_done_q;
    logic                   col_flag_q, col_flag_d, collision_q, collision_d;
    logic [23:0]            rgb_q, rgb_d;

    assign vblank_start = (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));
    assign fetch_en     = (state_q == S_IDLE) && !vblank_start;

    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // The address register is loaded on entry to ISSUE so the RAM sees it during ISSUE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (vblank_start) begin
                    state_d = S_ISSUE;
                    idx_d   = '0;
                end
            end
            S_ISSUE: state_d = S_CAPTURE;
            S_CAPTURE: begin
                capture = 1'b1;
                if (idx_q == IW'(NW - 1)) begin
                    state_d = S_COMMIT;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_COMMIT: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ld_addr_en = (state_d == S_ISSUE) || (state_d == S_CAPTURE);
        ld_addr    = POS_BASE + ADDR_WIDTH'(idx_d);
    end

    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x_q[i]   <= '0;
                sh_y_q[i]   <= '0;
                sh_en_q[i]  <= 1'b0;
                act_x_q[i]  <= '0;
                act_y_q[i]  <= '0;
                act_en_q[i] <= 1'b0;
`ifdef SPRITE_HFLIP_EN
                sh_fl_q[i]  <= 1'b0;
                act_fl_q[i] <= 1'b0;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (capture && ((idx_q >> 1) == IW'(i))) begin
                    if (!idx_q[0]) begin
                        sh_x_q[i] <= ram_q[9:0];
                    end else begin
                        sh_y_q[i]  <= ram_q[9:0];
                        sh_en_q[i] <= ram_q[15];
`ifdef SPRITE_HFLIP_EN
                        sh_fl_q[i] <= ram_q[14];
`endif
                    end
                end
                if (commit) begin
                    act_x_q[i]  <= sh_x_q[i];
                    act_y_q[i]  <= sh_y_q[i];
                    act_en_q[i] <= sh_en_q[i];
`ifdef SPRITE_HFLIP_EN
                    act_fl_q[i] <= sh_fl_q[i];
`endif
                end
            end
        end
    end

    // 11-bit compares so sprites near the right/bottom edge clip instead of wrapping.
    always_comb begin
        hit       = '0;
        any_hit   = 1'b0;
        multi_hit = 1'b0;
        win       = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            hit[i] = fetch_en && bright && act_en_q[i]
                  && ({1'b0, hcount} >= {1'b0, act_x_q[i]})
                  && ({1'b0, hcount} <  ({1'b0, act_x_q[i]} + SPAN_X))
                  && ({1'b0, vcount} >= {1'b0, act_y_q[i]})
                  && ({1'b0, vcount} <  ({1'b0, act_y_q[i]} + SPAN_Y));
            if (hit[i]) begin
                multi_hit = multi_hit | any_hit;
                any_hit   = 1'b1;
                win       = SW'(i);
            end
        end
        dx  = hcount - act_x_q[win];
        dy  = vcount - act_y_q[win];
        col = dx / 10'(SCALE);
        row = dy / 10'(SCALE);
`ifdef SPRITE_HFLIP_EN
        if (act_fl_q[win]) col = 10'(SPRITE_WIDTH - 1) - col;
`endif
        fetch_addr = SPR_BASE + ADDR_WIDTH'(win * SPR_STRIDE)
                   + ADDR_WIDTH'(row * SPRITE_WIDTH) + ADDR_WIDTH'(col);
        ram_addr_d = ld_addr_en ? ld_addr : (any_hit ? fetch_addr : '0);
    end

    always_comb begin
        rgb_d = BG_RGB;
        if (!b2_q) begin
            rgb_d = '0;
        end else if (v2_q && ram_q[15]) begin
            rgb_d = {ram_q[14:10], ram_q[14:12], ram_q[9:5], ram_q[9:7], ram_q[4:0], ram_q[4:2]};
        end
        col_flag_d  = vblank_start ? 1'b0 : (col_flag_q | multi_hit);
        collision_d = vblank_start ? col_flag_q : collision_q;
    end

    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            ram_addr_q   <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            b1_q         <= 1'b0;
            b2_q         <= 1'b0;
            rgb_q        <= '0;
            bright_out_q <= 1'b0;
            load_done_q  <= 1'b0;
            col_flag_q   <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            ram_addr_q   <= ram_addr_d;
            v1_q         <= any_hit;
            v2_q         <= v1_q;
            b1_q         <= bright;
            b2_q         <= b1_q;
            rgb_q        <= rgb_d;
            bright_out_q <= b2_q;
            load_done_q  <= commit;
            col_flag_q   <= col_flag_d;
            collision_q  <= collision_d;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign ram_we     = 1'b0;
    assign vga_r      = rgb_q[23:16];
    assign vga_g      = rgb_q[15:8];
    assign vga_b      = rgb_q[7:0];
    assign bright_out = bright_out_q;
    assign load_done  = load_done_q;
    assign collision  = collision_q;

endmodule

// File: tb/tb_vga_sprite_table_engine.sv
// Bench for vga_sprite_table_engine: directed scenarios plus random tables against an arithmetic sprite model.
module tb_vga_sprite_table_engine;

    localparam int NSPR   = 4;
    localparam int POS    = 32'h8000;
    localparam int STRIDE = 1024;
    localparam int SW     = 32;
    localparam int SH     = 32;
    localparam int SC     = 3;
    localparam logic [23:0] BG = 24'h88CC88;

    logic        pix_clk = 1'b0;
    logic        reset;
    logic [9:0]  hcount, vcount;
    logic        bright;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_q = 16'h0;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        bright_out, load_done, collision;

    vga_sprite_table_engine dut (
        .pix_clk(pix_clk), .reset(reset), .hcount(hcount), .vcount(vcount), .bright(bright),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .bright_out(bright_out), .load_done(load_done), .collision(collision)
    );

    always #5 pix_clk = ~pix_clk;

    logic [15:0] mem [65536];
    always @(posedge pix_clk) ram_q <= mem[ram_addr];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int m_x [NSPR];
    int m_y [NSPR];
    int m_en [NSPR];
    bit m_flag = 0;
    bit m_collision = 0;
    int          e_addr [65536];
    logic [23:0] e_rgb [65536];
    bit          e_b [65536];
    bit          e_ok [65536];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int expand(input int c5);
        return (c5 * 8) + (c5 / 4);
    endfunction

    function automatic void model(input int h, input int v, input int b,
                                  output int addr, output logic [23:0] rgb, output int hits);
        logic [15:0] w;
        hits = 0;
        addr = 0;
        rgb  = b ? BG : 24'h0;
        if (b == 0) return;
        for (int i = 0; i < NSPR; i++) begin
            if (m_en[i] != 0 && h >= m_x[i] && h < m_x[i] + SW * SC
                && v >= m_y[i] && v < m_y[i] + SH * SC) begin
                hits++;
                if (hits == 1) begin
                    addr = (i * STRIDE + ((v - m_y[i]) / SC) * SW + (h - m_x[i]) / SC) % 65536;
                    w = mem[addr];
                    if (w[15])
                        rgb = 24'(expand(int'(w[14:10])) * 65536 + expand(int'(w[9:5])) * 256
                                  + expand(int'(w[4:0])));
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge pix_clk);
        #1;
        cyc++;
        e_ok[cyc] = 0;
    endtask

    task automatic step(input int h, input int v, input int b);
        int a, hits;
        logic [23:0] c;
        hcount = 10'(h);
        vcount = 10'(v);
        bright = b[0];
        model(h, v, b, a, c, hits);
        if (hits >= 2) m_flag = 1;
        @(posedge pix_clk);
        #1;
        cyc++;
        e_addr[cyc] = a;
        e_rgb[cyc]  = c;
        e_b[cyc]    = b[0];
        e_ok[cyc]   = 1;
        check("ram_addr", ram_addr, a);
        check("load_done_idle", load_done, 0);
        if (cyc >= 2 && e_ok[cyc-2]) begin
            check("rgb", {vga_r, vga_g, vga_b}, e_rgb[cyc-2]);
            check("bright_out", bright_out, e_b[cyc-2]);
        end
    endtask

    task automatic sweep(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) step(h, v, 1);
        step(h1, v, 0);
        step(h1, v, 0);
    endtask

    task automatic set_spr(input int i, input int x, input int y, input int en);
        mem[POS + 2*i]     = {6'($urandom), 10'(x)};
        mem[POS + 2*i + 1] = {en[0], 5'($urandom), 10'(y)};
    endtask

    task automatic load_table();
        for (int i = 0; i < NSPR; i++) begin
            m_x[i]  = int'(mem[POS + 2*i][9:0]);
            m_y[i]  = int'(mem[POS + 2*i + 1][9:0]);
            m_en[i] = int'(mem[POS + 2*i + 1][15]);
        end
    endtask

    task automatic do_vblank();
        hcount = 10'd0;
        vcount = 10'd480;
        bright = 1'b0;
        tick();
        m_collision = m_flag;
        m_flag = 0;
        check("collision", collision, m_collision);
        for (int k = 1; k <= 20; k++) begin
            hcount = 10'(k);
            tick();
            check("load_done", load_done, (k == 17) ? 1 : 0);
        end
        load_table();
    endtask

    initial begin
        int x, y, j, v, h0;
        reset = 1'b1;
        hcount = 10'd0;
        vcount = 10'd0;
        bright = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0;
        for (int i = 0; i < NSPR; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_en[i] = 0;
        end
        repeat (3) @(posedge pix_clk);
        #1;
        check("rst_ram_addr", ram_addr, 0);
        check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        check("rst_bright_out", bright_out, 0);
        check("rst_load_done", load_done, 0);
        check("rst_collision", collision, 0);
        check("ram_we", ram_we, 0);
        reset = 1'b0;

        // All sprites disabled: background and dummy reads.
        for (int a = 0; a < NSPR * STRIDE; a++) mem[a] = 16'($urandom);
        sweep(10, 0, 40);
        do_vblank();
        sweep(10, 0, 40);

        // Single red sprite at (100,50).
        set_spr(0, 100, 50, 1);
        mem[0] = 16'hFC00;
        do_vblank();
        step(100, 50, 1);
        step(101, 50, 1);
        step(102, 50, 1);
        check("red_pixel", {vga_r, vga_g, vga_b}, 24'hFF0000);
        sweep(50, 96, 200);
        sweep(80, 90, 200);

        // Overlap: sprite0 row 0 transparent, elsewhere opaque; sprite1 fully opaque.
        set_spr(0, 300, 300, 1);
        set_spr(1, 300, 300, 1);
        for (int a = 0; a < STRIDE; a++) begin
            mem[a] = 16'($urandom) | 16'h8000;
            mem[STRIDE + a] = 16'($urandom) | 16'h8000;
        end
        for (int a = 0; a < SW; a++) mem[a] = mem[a] & 16'h7FFF;
        do_vblank();
        sweep(301, 290, 400);
        sweep(330, 290, 400);
        set_spr(1, 600, 100, 1);
        do_vblank();
        check("collision_set", collision, 1);
        sweep(120, 590, 700);
        do_vblank();
        check("collision_clear", collision, 0);

        // Right-edge clipping, no wrap to hcount 0.
        set_spr(0, 0, 0, 0);
        set_spr(1, 0, 0, 0);
        set_spr(2, 1000, 200, 1);
        do_vblank();
        sweep(210, 990, 1023);
        sweep(210, 0, 10);

        // Random tables and pixel data.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NSPR; i++)
                set_spr(i, $urandom_range(0, 1023), $urandom_range(0, 380), $urandom_range(0, 3) != 0);
            for (int a = 0; a < NSPR * STRIDE; a++) mem[a] = 16'($urandom);
            do_vblank();
            for (int s = 0; s < 4; s++) begin
                j  = $urandom_range(0, NSPR - 1);
                v  = m_y[j] + $urandom_range(0, 99);
                h0 = m_x[j] - 10;
                if (h0 < 0) h0 = 0;
                if (h0 > 900) h0 = 900;
                sweep(v, h0, h0 + 120);
            end
        end

        // Reset during CAPTURE of word 3 aborts the load.
        for (int i = 0; i < NSPR; i++) set_spr(i, 200 + 40 * i, 100, 1);
        hcount = 10'd0;
        vcount = 10'd480;
        bright = 1'b0;
        tick();
        hcount = 10'd5;
        repeat (7) tick();
        #2;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_mid_load_done", load_done, 0);
        end
        check("rst_mid_collision", collision, 0);
        reset = 1'b0;
        for (int i = 0; i < NSPR; i++) m_en[i] = 0;
        m_flag = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("no_commit_after_rst", load_done, 0);
        end
        sweep(120, 180, 400);
        do_vblank();
        sweep(120, 180, 400);
        x = 0; y = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
